// File: rtl/tpu_program_sequencer.sv
// Program sequencer for the TPU instruction path. While idle, the host loads
// instruction words into a single-port icache. On start, words are fetched
// from address 0 upward and handed to the controller. The run ends on a word
// with the finish bit set, or after address 1023 has been fetched (overflow).
module tpu_program_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  // Host load port
  input  logic        i_host_wr_valid,
  output logic        o_host_wr_ready,
  input  logic [9:0]  i_host_wr_addr,
  input  logic [53:0] i_host_wr_data,
  // Host control
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_pause,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err_overflow,
  // Icache port, 1-cycle read latency
  output logic        o_icache_en,
  output logic        o_icache_we,
  output logic [9:0]  o_icache_addr,
  output logic [53:0] o_icache_wdata,
  input  logic [53:0] i_icache_rdata,
  // Controller port
  output logic        o_instr_valid,
  output logic [53:0] o_instr_data,
  output logic [10:0] o_instr_count
);

  localparam int unsigned FinishBit = 53;
  localparam logic [9:0]  LastPc    = 10'h3ff;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e      r_state;
  logic [9:0]  r_pc;
  logic [10:0] r_count;
  logic        r_valid;    // a read was issued last cycle; its word is on i_icache_rdata now
  logic        r_err;
  logic        r_busy;
  logic        r_done;
  logic        r_ready;    // low through reset, high from the first edge after release

  state_e      w_state_d;
  logic [9:0]  w_pc_d;
  logic [10:0] w_count_d;
  logic        w_err_d;
  logic        w_valid_d;
  logic        w_idle;
  logic        w_host_wr;
  logic        w_issue;
  logic        w_finish;

  assign w_idle    = (r_state == StIdle);
  assign w_host_wr = w_idle && r_ready && i_host_wr_valid;
  assign w_issue   = (r_state == StRun) && !i_pause && !i_abort;
  assign w_finish  = r_valid && i_icache_rdata[FinishBit];

  // Icache port: host writes in idle, instruction fetch reads in run
  always_comb begin
    o_icache_en    = w_host_wr || w_issue;
    o_icache_we    = w_host_wr;
    o_icache_addr  = w_host_wr ? i_host_wr_addr : r_pc;
    o_icache_wdata = w_host_wr ? i_host_wr_data : '0;
  end

  // Host and controller facing outputs
  always_comb begin
    o_host_wr_ready = r_ready && w_idle;
    o_busy          = r_busy;
    o_done          = r_done;
    o_err_overflow  = r_err;
    o_instr_valid   = r_valid;
    o_instr_data    = r_valid ? i_icache_rdata : '0;
    o_instr_count   = r_count;
  end

  // Next-state and datapath decisions; abort overrides everything else
  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_count_d = r_count + {10'd0, r_valid};
    w_err_d   = r_err;
    w_valid_d = 1'b0;
    if (i_abort) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_state_d = StRun;
            w_pc_d    = '0;
            w_count_d = '0;
            w_err_d   = 1'b0;
          end
        end
        StRun: begin
          if (w_issue) begin
            w_valid_d = 1'b1;
            // The fetch at the last address is the final one; pc must not wrap
            if (r_pc == LastPc) begin
              w_state_d = StDrain;
            end else begin
              w_pc_d = r_pc + 10'd1;
            end
          end
          // Finish seen: squash the read issued alongside it
          if (w_finish) begin
            w_state_d = StDone;
            w_valid_d = 1'b0;
          end
        end
        StDrain: begin
          w_state_d = StDone;
          if (!w_finish) begin
            w_err_d = 1'b1;
          end
        end
        StDone: begin
          w_state_d = StIdle;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  // State register with registered busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_count <= w_count_d;
      r_valid <= w_valid_d;
      r_err   <= w_err_d;
      r_busy  <= (w_state_d == StRun) || (w_state_d == StDrain);
      r_done  <= (w_state_d == StDone);
      r_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tpu_program_sequencer.sv
// Bench for tpu_program_sequencer: icache behavioural memory, an event monitor,
// and a program-level reference model that walks the loaded program image.
module tb_tpu_program_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_host_wr_valid;
  logic        o_host_wr_ready;
  logic [9:0]  i_host_wr_addr;
  logic [53:0] i_host_wr_data;
  logic        i_start;
  logic        i_abort;
  logic        i_pause;
  logic        o_busy;
  logic        o_done;
  logic        o_err_overflow;
  logic        o_icache_en;
  logic        o_icache_we;
  logic [9:0]  o_icache_addr;
  logic [53:0] o_icache_wdata;
  logic [53:0] i_icache_rdata;
  logic        o_instr_valid;
  logic [53:0] o_instr_data;
  logic [10:0] o_instr_count;

  tpu_program_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_host_wr_valid (i_host_wr_valid),
    .o_host_wr_ready (o_host_wr_ready),
    .i_host_wr_addr  (i_host_wr_addr),
    .i_host_wr_data  (i_host_wr_data),
    .i_start         (i_start),
    .i_abort         (i_abort),
    .i_pause         (i_pause),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err_overflow  (o_err_overflow),
    .o_icache_en     (o_icache_en),
    .o_icache_we     (o_icache_we),
    .o_icache_addr   (o_icache_addr),
    .o_icache_wdata  (o_icache_wdata),
    .i_icache_rdata  (i_icache_rdata),
    .o_instr_valid   (o_instr_valid),
    .o_instr_data    (o_instr_data),
    .o_instr_count   (o_instr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Icache: single port, one-cycle read latency
  logic [53:0] mem [1024];
  logic [53:0] ref_mem [1024];
  always @(posedge clk) begin
    if (o_icache_en) begin
      if (o_icache_we) mem[o_icache_addr] <= o_icache_wdata;
      else             i_icache_rdata <= mem[o_icache_addr];
    end
  end

  // Monitor, sampled on the falling edge
  logic [53:0] got_q [$];
  int          got_cyc_q [$];
  logic [9:0]  rd_q [$];
  int          done_cnt, done_cyc, nop_bad, wr_bad;
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_instr_valid) begin
        got_q.push_back(o_instr_data);
        got_cyc_q.push_back(cyc);
      end else if (o_instr_data != 54'h0) begin
        nop_bad = nop_bad + 1;
      end
      if (o_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (o_icache_en && !o_icache_we) rd_q.push_back(o_icache_addr);
      if (o_busy && (o_host_wr_ready || o_icache_we)) wr_bad = wr_bad + 1;
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [53:0] rnd_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return {1'b0, t[52:0]};
  endfunction

  task automatic host_write(input int a, input logic [53:0] d);
    i_host_wr_valid = 1'b1;
    i_host_wr_addr  = a[9:0];
    i_host_wr_data  = d;
    ref_mem[a]      = d;
    tick();
    i_host_wr_valid = 1'b0;
  endtask

  // Random program of len words, finish bit on the last one
  task automatic load_prog(input int len);
    logic [53:0] w;
    for (int i = 0; i < len; i++) begin
      w = rnd_word();
      if (i == len - 1) w[53] = 1'b1;
      host_write(i, w);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_cyc_q.delete();
    rd_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  // Reference: the program is the image from address 0 up to the first finish word,
  // or all 1024 words (overflow) when none carries the finish bit.
  logic [53:0] exp_q [$];
  logic        exp_err;
  task automatic model_expect();
    exp_q.delete();
    exp_err = 1'b1;
    for (int a = 0; a < 1024; a++) begin
      exp_q.push_back(ref_mem[a]);
      if (ref_mem[a][53]) begin
        exp_err = 1'b0;
        break;
      end
    end
  endtask

  int start_cyc;

  // mode 0: no pause, 1: random pause, 2: pause in cycles start+3/+4, 3: host writes during run
  task automatic run_prog(input int mode, input int budget);
    int n;
    clear_mon();
    i_start   = 1'b1;
    start_cyc = cyc;
    tick();
    i_start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      case (mode)
        1: i_pause = ($urandom_range(0, 3) == 0);
        2: i_pause = ((cyc - start_cyc) == 3) || ((cyc - start_cyc) == 4);
        3: begin
          i_host_wr_valid = 1'b1;
          i_host_wr_addr  = 10'($urandom_range(0, 1023));
          i_host_wr_data  = rnd_word();
        end
        default: i_pause = 1'b0;
      endcase
      tick();
      n++;
    end
    i_pause         = 1'b0;
    i_host_wr_valid = 1'b0;
    check("run_finished", (done_cnt != 0), 1);
    tick();
    tick();
  endtask

  task automatic check_run(input string tag);
    model_expect();
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_word"}, got_q[i], exp_q[i]);
    end
    check({tag, "_count"}, o_instr_count, exp_q.size());
    check({tag, "_err"}, o_err_overflow, exp_err);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_after"}, o_busy, 0);
  endtask

  int exp_off [4] = '{2, 3, 6, 7};

  initial begin
    int diff;
    nop_bad = 0;
    wr_bad  = 0;
    for (int a = 0; a < 1024; a++) begin
      mem[a]     = '0;
      ref_mem[a] = '0;
    end
    clear_mon();
    rst_n           = 1'b0;
    i_host_wr_valid = 1'b1;   // must not reach the icache during reset
    i_host_wr_addr  = '0;
    i_host_wr_data  = '1;
    i_start         = 1'b0;
    i_abort         = 1'b0;
    i_pause         = 1'b0;
    #3;
    check("rst_ready", o_host_wr_ready, 0);
    check("rst_en", o_icache_en, 0);
    check("rst_we", o_icache_we, 0);
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_instr_valid, 0);
    check("rst_count", o_instr_count, 0);
    tick();
    tick();
    i_host_wr_valid = 1'b0;
    rst_n = 1'b1;
    check("ready_before_edge", o_host_wr_ready, 0);
    tick();
    check("ready_after_edge", o_host_wr_ready, 1);

    // Basic four-word program
    host_write(0, 54'h1);
    host_write(1, 54'h2);
    host_write(2, 54'h3);
    host_write(3, 54'h20_0000_0000_0000);
    run_prog(0, 50);
    check_run("basic");
    for (int k = 0; k < 4 && k < got_cyc_q.size(); k++) begin
      check("basic_deliver_cyc", got_cyc_q[k] - start_cyc, k + 2);
    end
    check("basic_done_cyc", done_cyc - start_cyc, 6);
    check("basic_reads", rd_q.size(), 5);
    if (rd_q.size() == 5) check("basic_squashed_addr", rd_q[4], 4);

    // Same program with a two-cycle pause after the second delivery
    run_prog(2, 50);
    check_run("pause");
    for (int k = 0; k < 4 && k < got_cyc_q.size(); k++) begin
      check("pause_deliver_cyc", got_cyc_q[k] - start_cyc, exp_off[k]);
    end
    check("pause_done_cyc", done_cyc - start_cyc, 8);

    // Random programs with random pausing
    for (int t = 0; t < 6; t++) begin
      load_prog($urandom_range(1, 40));
      run_prog(1, 400);
      check_run("rnd");
    end

    // Host writes attempted throughout a run
    load_prog(12);
    run_prog(3, 200);
    check_run("hostwr");
    diff = 0;
    for (int a = 0; a < 1024; a++) if (mem[a] !== ref_mem[a]) diff++;
    check("hostwr_mem_intact", diff, 0);

    // No finish anywhere: overflow
    for (int a = 0; a < 1024; a++) host_write(a, 54'h0);
    run_prog(0, 1100);
    check_run("ovf");
    check("ovf_reads", rd_q.size(), 1024);
    if (rd_q.size() == 1024) check("ovf_last_addr", rd_q[1023], 1023);

    // Abort while idle leaves the sticky error alone
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_idle_err", o_err_overflow, 1);

    // Abort in the third run cycle
    load_prog(20);
    clear_mon();
    i_start   = 1'b1;
    start_cyc = cyc;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_busy", o_busy, 0);
    check("abort_valid", o_instr_valid, 0);
    check("abort_ready", o_host_wr_ready, 1);
    tick();
    tick();
    check("abort_no_done", done_cnt, 0);

    // Reset mid-run
    clear_mon();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_valid", o_instr_valid, 0);
    check("mid_rst_data", o_instr_data, 0);
    check("mid_rst_count", o_instr_count, 0);
    check("mid_rst_en", o_icache_en, 0);
    check("mid_rst_ready", o_host_wr_ready, 0);
    check("mid_rst_done", o_done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", o_host_wr_ready, 1);
    check("post_rst_busy", o_busy, 0);
    tick();
    check("post_rst_no_done", done_cnt, 0);

    check("nop_when_invalid", nop_bad, 0);
    check("no_write_while_busy", wr_bad, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
